mips_run_monitor: RTL

//   Synthesisable run-control and self-check monitor for the multicycle MIPS core.
//   - Watches the fetch stream and detects the HALT opcode; enforces a cycle-timeout watchdog.
//   - After HALT, reads NUM_CHECKS architectural registers through the register-file debug port.
//   - Compares each against its expected value and raises sticky done/pass/fail/timeout flags.
//   - Sits beside mips_multicycle in benches and FPGA bring-up tops, replacing ad-hoc bench checks.

---
 rtl/mips_run_monitor_if.sv | 37 +++
 rtl/mips_run_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_monitor_if.sv
// mips_run_monitor_if
//   Groups the fetch-stream observation signals and the register-file
//   debug read port shared by the MIPS core side and the run monitor.
//   Signals:
//     instr_valid  instr/pc hold a newly fetched instruction this cycle
//     instr        fetched instruction word
//     pc           address of instr
//     dbg_raddr    register-file debug read address (driven by the monitor)
//     dbg_rdata    register-file debug read data (driven by the core side)
//   Modports:
//     master  core / register-file side
//     slave   monitor side
interface mips_run_monitor_if #(
  parameter int WIDTH = 32
) ();
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] pc;
  logic [4:0]       dbg_raddr;
  logic [WIDTH-1:0] dbg_rdata;

  modport master (
    output instr_valid,
    output instr,
    output pc,
    output dbg_rdata,
    input  dbg_raddr
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  pc,
    input  dbg_rdata,
    output dbg_raddr
  );
endinterface

// File: rtl/mips_run_monitor.sv
// mips_run_monitor
//   Run-control and self-check monitor for the multicycle MIPS core.
//   Watches the fetch stream for the HALT word, runs a cycle watchdog, then
//   reads NUM_CHECKS registers through the debug port and compares them with
//   their expected values. All result flags are sticky until reset.
//   Optional feature macro: MONITOR_PC_HIST_EN builds a PC history buffer
//   readable through hist_idx/hist_pc; without it hist_pc is tied to 0.
//   Ports:
//     clk, reset    clock (rising edge), asynchronous active-high reset
//     bus           fetch stream + register-file debug port (slave modport)
//     exp_addr      packed register numbers to check, entry i = [5i+4:5i]
//     exp_data      packed expected values, entry i = [WIDTH*i +: WIDTH]
//     done/pass/fail/timeout  sticky result flags
//     fail_index    index of the first mismatching check
//     halt_pc       pc of the HALT instruction
//     cycle_count   cycles spent in RUN (saturating)
//     instr_count   instr_valid pulses seen in RUN, HALT included (saturating)
//     hist_idx      PC history select, 0 = newest
//     hist_pc       selected PC history entry (combinational read)
module mips_run_monitor #(
  parameter int               WIDTH          = 32,
  parameter int               NUM_CHECKS     = 3,
  parameter logic [WIDTH-1:0] HALT_OPCODE    = 32'hfc000000,
  parameter int               TIMEOUT_CYCLES = 2000,
  parameter int               CNT_W          = 16,
  parameter int               HIST_DEPTH     = 8,
  localparam int              IDX_W          = $clog2(NUM_CHECKS) + 1,
  localparam int              HIST_W         = $clog2(HIST_DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_run_monitor_if.slave           bus,
  input  logic [5*NUM_CHECKS-1:0]     exp_addr,
  input  logic [WIDTH*NUM_CHECKS-1:0] exp_data,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        timeout,
  output logic [IDX_W-1:0]            fail_index,
  output logic [WIDTH-1:0]            halt_pc,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            instr_count,
  input  logic [HIST_W-1:0]           hist_idx,
  output logic [WIDTH-1:0]            hist_pc
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CHK_ADDR = 2'd1,
    ST_CHK_DATA = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [4:0]         dbg_raddr_r, dbg_raddr_s;
  logic               done_r, done_s;
  logic               pass_r, pass_s;
  logic               fail_r, fail_s;
  logic               timeout_r, timeout_s;
  logic [IDX_W-1:0]   fail_index_r, fail_index_s;
  logic [WIDTH-1:0]   halt_pc_r, halt_pc_s;
  logic [CNT_W-1:0]   cycle_count_r, cycle_count_s;
  logic [CNT_W-1:0]   instr_count_r, instr_count_s;
  logic               halt_hit_s;
  logic [WIDTH-1:0]   cur_exp_s;

  assign halt_hit_s = bus.instr_valid && (bus.instr == HALT_OPCODE);
  assign cur_exp_s  = exp_data[WIDTH*int'(idx_r) +: WIDTH];

  // Next-state and next-output logic for the run/check sequencer.
  // dbg_raddr is loaded on the edge that enters CHK_ADDR so the register
  // file has the whole CHK_ADDR cycle to return data sampled in CHK_DATA.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    dbg_raddr_s   = dbg_raddr_r;
    done_s        = done_r;
    pass_s        = pass_r;
    fail_s        = fail_r;
    timeout_s     = timeout_r;
    fail_index_s  = fail_index_r;
    halt_pc_s     = halt_pc_r;
    cycle_count_s = cycle_count_r;
    instr_count_s = instr_count_r;
    case (state_r)
      ST_RUN: begin
        if (cycle_count_r != CNT_MAX) begin
          cycle_count_s = cycle_count_r + CNT_W'(1);
        end else begin
          cycle_count_s = cycle_count_r;
        end
        if (bus.instr_valid && (instr_count_r != CNT_MAX)) begin
          instr_count_s = instr_count_r + CNT_W'(1);
        end else begin
          instr_count_s = instr_count_r;
        end
        // HALT takes priority over a watchdog expiry on the same edge
        if (halt_hit_s) begin
          halt_pc_s   = bus.pc;
          idx_s       = '0;
          dbg_raddr_s = exp_addr[4:0];
          state_s     = ST_CHK_ADDR;
        end else if (cycle_count_r == TO_LAST) begin
          timeout_s = 1'b1;
          fail_s    = 1'b1;
          done_s    = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_CHK_ADDR: begin
        state_s = ST_CHK_DATA;
      end
      ST_CHK_DATA: begin
        if (bus.dbg_rdata != cur_exp_s) begin
          fail_s       = 1'b1;
          done_s       = 1'b1;
          fail_index_s = idx_r;
          state_s      = ST_DONE;
        end else if (idx_r == LAST_IDX) begin
          pass_s  = 1'b1;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          idx_s       = idx_r + IDX_W'(1);
          dbg_raddr_s = exp_addr[5*(int'(idx_r) + 1) +: 5];
          state_s     = ST_CHK_ADDR;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State and registered-output update; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      idx_r         <= '0;
      dbg_raddr_r   <= 5'd0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      timeout_r     <= 1'b0;
      fail_index_r  <= '0;
      halt_pc_r     <= '0;
      cycle_count_r <= '0;
      instr_count_r <= '0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      dbg_raddr_r   <= dbg_raddr_s;
      done_r        <= done_s;
      pass_r        <= pass_s;
      fail_r        <= fail_s;
      timeout_r     <= timeout_s;
      fail_index_r  <= fail_index_s;
      halt_pc_r     <= halt_pc_s;
      cycle_count_r <= cycle_count_s;
      instr_count_r <= instr_count_s;
    end
  end

  assign bus.dbg_raddr = dbg_raddr_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign fail          = fail_r;
  assign timeout       = timeout_r;
  assign fail_index    = fail_index_r;
  assign halt_pc       = halt_pc_r;
  assign cycle_count   = cycle_count_r;
  assign instr_count   = instr_count_r;

`ifdef MONITOR_PC_HIST_EN
  logic [WIDTH-1:0]  hist_r [HIST_DEPTH];
  logic [HIST_W-1:0] wptr_r;

  // Circular PC history, written on every fetch while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_r[i] <= '0;
      end
      wptr_r <= '0;
    end else if ((state_r == ST_RUN) && bus.instr_valid) begin
      hist_r[wptr_r] <= bus.pc;
      wptr_r         <= wptr_r + HIST_W'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Newest entry sits one slot behind the write pointer; wrap is modulo depth.
  assign hist_pc = hist_r[wptr_r - HIST_W'(1) - hist_idx];
`else
  logic unused_hist_idx_s;
  assign unused_hist_idx_s = ^hist_idx;
  assign hist_pc           = '0;
`endif

endmodule
